maze_navigator: RTL and testbench

MAZE_NAVIGATOR -- requirements
Module: maze_navigator

---
 rtl/maze_navigator_if.sv | 32 +++
 rtl/maze_navigator.sv | 115 +++++++++++
 tb/tb_maze_navigator.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/maze_navigator_if.sv
// Bundle of the maze navigator's load, button and status signals.
// The driver side uses master; the navigator itself uses slave.
interface maze_navigator_if #(
   parameter int MAZE_W = 20,
   parameter int MAZE_H = 20
);
   logic                       load;
   logic [MAZE_W*MAZE_H-1:0]   maze;
   logic [9:0]                 player_start;
   logic [9:0]                 player_end;
   logic                       btn_up;
   logic                       btn_down;
   logic                       btn_left;
   logic                       btn_right;
   logic [9:0]                 player_pos;
   logic [15:0]                move_count;
   logic                       playing;
   logic                       won;
   logic                       bump;

   modport master (
      output load, maze, player_start, player_end,
      output btn_up, btn_down, btn_left, btn_right,
      input  player_pos, move_count, playing, won, bump
   );

   modport slave (
      input  load, maze, player_start, player_end,
      input  btn_up, btn_down, btn_left, btn_right,
      output player_pos, move_count, playing, won, bump
   );
endinterface

// File: rtl/maze_navigator.sv
// Grid maze game: a player token moves one cell per button press through a
// loaded wall map until it reaches the goal cell.
module maze_navigator #(
   parameter int MAZE_W = 20,
   parameter int MAZE_H = 20
) (
   input logic              clk,
   input logic              rst_n,
   maze_navigator_if.slave  bus
);
   localparam int CELLS = MAZE_W * MAZE_H;
   localparam int IDX_W = $clog2(CELLS);

   typedef enum logic [1:0] {IDLE, PLAY, WON} state_t;

   state_t             state_reg, state_next;
   logic [CELLS-1:0]   maze_reg;
   logic [9:0]         end_reg;
   logic [3:0]         btn_vec, btn_reg, press;
   logic [9:0]         pos_reg, pos_next;
   logic [15:0]        count_reg, count_next;
   logic               bump_reg, bump_next;

   logic [5:0]         t_row, t_col;
   logic [9:0]         target_pos;
   logic [IDX_W-1:0]   cell_idx;
   logic               in_range, blocked, single_press;

   // Bit order: 0 up, 1 down, 2 left, 3 right.
   assign btn_vec = {bus.btn_right, bus.btn_left, bus.btn_down, bus.btn_up};

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_press
         assign press[gi] = btn_vec[gi] & ~btn_reg[gi];
      end
   endgenerate

   assign single_press = $onehot(press);

   // Six-bit arithmetic: stepping below 0 wraps to 63, which the range check rejects.
   always_comb begin
      t_row = {1'b0, pos_reg[9:5]};
      t_col = {1'b0, pos_reg[4:0]};
      if (press[0])
         t_row = {1'b0, pos_reg[9:5]} - 6'd1;
      else if (press[1])
         t_row = {1'b0, pos_reg[9:5]} + 6'd1;
      else if (press[2])
         t_col = {1'b0, pos_reg[4:0]} - 6'd1;
      else if (press[3])
         t_col = {1'b0, pos_reg[4:0]} + 6'd1;
   end

   assign in_range   = (t_row < 6'(MAZE_H)) && (t_col < 6'(MAZE_W));
   assign cell_idx   = IDX_W'(int'(t_row) * MAZE_W + int'(t_col));
   assign blocked    = !in_range || maze_reg[cell_idx];
   assign target_pos = {t_row[4:0], t_col[4:0]};

   // Captured game setup; the wall lookup never sees the live maze input.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         maze_reg <= '0;
         end_reg  <= '0;
      end else if (bus.load) begin
         maze_reg <= bus.maze;
         end_reg  <= bus.player_end;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= IDLE;
         pos_reg   <= '0;
         count_reg <= '0;
         bump_reg  <= 1'b0;
         btn_reg   <= '0;
      end else begin
         state_reg <= state_next;
         pos_reg   <= pos_next;
         count_reg <= count_next;
         bump_reg  <= bump_next;
         btn_reg   <= btn_vec;
      end
   end

   always_comb begin
      state_next = state_reg;
      pos_next   = pos_reg;
      count_next = count_reg;
      bump_next  = 1'b0;
      if (bus.load) begin
         pos_next   = bus.player_start;
         count_next = '0;
         state_next = (bus.player_start == bus.player_end) ? WON : PLAY;
      end else if (state_reg == PLAY && single_press) begin
         if (blocked) begin
            bump_next = 1'b1;
         end else begin
            pos_next   = target_pos;
            count_next = (count_reg == 16'hFFFF) ? count_reg : count_reg + 16'd1;
            if (target_pos == end_reg)
               state_next = WON;
         end
      end
   end

   always_comb begin
      bus.playing    = (state_reg == PLAY);
      bus.won        = (state_reg == WON);
      bus.player_pos = pos_reg;
      bus.move_count = count_reg;
      bus.bump       = bump_reg;
   end
endmodule

// File: tb/tb_maze_navigator.sv
// Directed bench for maze_navigator: win, walls/edges, held and simultaneous
// buttons, load collision, asynchronous reset and move-count saturation.
module tb_maze_navigator;
   logic clk;
   logic rst_n;
   int   n_vec;
   int   n_err;

   maze_navigator_if #(.MAZE_W(20), .MAZE_H(20)) nav_bus ();

   maze_navigator #(.MAZE_W(20), .MAZE_H(20)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (nav_bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: time limit reached before end of test");
      $fatal(1, "watchdog expired");
   end

   logic [399:0] maze_border;
   logic [399:0] maze_gap;

   function automatic logic [9:0] rc(input int r, input int c);
      return {5'(r), 5'(c)};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_load(input logic [399:0] m, input logic [9:0] s, input logic [9:0] e);
      nav_bus.maze         = m;
      nav_bus.player_start = s;
      nav_bus.player_end   = e;
      nav_bus.load         = 1'b1;
      step();
      nav_bus.load         = 1'b0;
   endtask

   task automatic chk_out(input string tag, input logic [9:0] pos, input logic [15:0] cnt,
                          input logic ply, input logic wn, input logic bmp);
      chk({tag, ".pos"},     32'(nav_bus.player_pos), 32'(pos));
      chk({tag, ".count"},   32'(nav_bus.move_count), 32'(cnt));
      chk({tag, ".playing"}, 32'(nav_bus.playing),    32'(ply));
      chk({tag, ".won"},     32'(nav_bus.won),        32'(wn));
      chk({tag, ".bump"},    32'(nav_bus.bump),       32'(bmp));
   endtask

   initial begin
      n_vec = 0;
      n_err = 0;
      for (int r = 0; r < 20; r++)
         for (int c = 0; c < 20; c++)
            maze_border[r*20+c] = (r == 0 || r == 19 || c == 0 || c == 19);
      maze_gap     = maze_border;
      maze_gap[20] = 1'b0;

      nav_bus.load = 1'b0;
      nav_bus.maze = '0;
      nav_bus.player_start = '0;
      nav_bus.player_end   = '0;
      nav_bus.btn_up = 1'b0; nav_bus.btn_down = 1'b0;
      nav_bus.btn_left = 1'b0; nav_bus.btn_right = 1'b0;
      rst_n = 1'b1;
      #1 rst_n = 1'b0;
      #1;
      chk_out("reset", rc(0,0), 16'd0, 1'b0, 1'b0, 1'b0);
      #20 rst_n = 1'b1;
      step();
      chk_out("idle", rc(0,0), 16'd0, 1'b0, 1'b0, 1'b0);

      // Open move onto the goal
      do_load(maze_border, rc(9,9), rc(9,8));
      chk_out("win.load", rc(9,9), 16'd0, 1'b1, 1'b0, 1'b0);
      nav_bus.btn_left = 1'b1;
      step();
      chk_out("win.move", rc(9,8), 16'd1, 1'b0, 1'b1, 1'b0);
      nav_bus.btn_left = 1'b0;
      step();
      nav_bus.btn_right = 1'b1;
      step();
      chk_out("win.ignore", rc(9,8), 16'd1, 1'b0, 1'b1, 1'b0);
      nav_bus.btn_right = 1'b0;
      step();

      // Start already on the goal
      do_load(maze_border, rc(4,4), rc(4,4));
      chk_out("startwin", rc(4,4), 16'd0, 1'b0, 1'b1, 1'b0);

      // Wall above
      do_load(maze_border, rc(1,1), rc(5,5));
      nav_bus.btn_up = 1'b1;
      step();
      chk_out("wall.up", rc(1,1), 16'd0, 1'b1, 1'b0, 1'b1);
      nav_bus.btn_up = 1'b0;
      step();
      chk("wall.bump_end", 32'(nav_bus.bump), 32'd0);

      // Left edge with an open border cell
      do_load(maze_gap, rc(1,0), rc(5,5));
      nav_bus.btn_left = 1'b1;
      step();
      chk_out("edge.left", rc(1,0), 16'd0, 1'b1, 1'b0, 1'b1);
      nav_bus.btn_left = 1'b0;
      step();
      chk("edge.bump_end", 32'(nav_bus.bump), 32'd0);

      // Held button, with the live maze input turned to solid wall
      do_load(maze_border, rc(5,5), rc(15,15));
      nav_bus.maze = '1;
      nav_bus.btn_down = 1'b1;
      step();
      chk_out("hold.first", rc(6,5), 16'd1, 1'b1, 1'b0, 1'b0);
      repeat (9) step();
      chk_out("hold.after", rc(6,5), 16'd1, 1'b1, 1'b0, 1'b0);
      nav_bus.btn_down = 1'b0;
      step();
      nav_bus.btn_up = 1'b1;
      nav_bus.btn_right = 1'b1;
      step();
      chk_out("dual", rc(6,5), 16'd1, 1'b1, 1'b0, 1'b0);
      nav_bus.btn_up = 1'b0;
      nav_bus.btn_right = 1'b0;
      step();

      // Load together with a button edge
      nav_bus.btn_right = 1'b1;
      do_load(maze_border, rc(3,3), rc(15,15));
      chk_out("collide", rc(3,3), 16'd0, 1'b1, 1'b0, 1'b0);
      step();
      chk_out("collide.held", rc(3,3), 16'd0, 1'b1, 1'b0, 1'b0);
      nav_bus.btn_right = 1'b0;
      step();

      // Three moves, then asynchronous reset
      nav_bus.btn_right = 1'b1; step(); nav_bus.btn_right = 1'b0; step();
      nav_bus.btn_down  = 1'b1; step(); nav_bus.btn_down  = 1'b0; step();
      nav_bus.btn_right = 1'b1; step();
      chk_out("three", rc(4,5), 16'd3, 1'b1, 1'b0, 1'b0);
      nav_bus.btn_right = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      chk_out("midreset", rc(0,0), 16'd0, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      step();
      nav_bus.btn_down = 1'b1;
      step();
      chk_out("postreset.down", rc(0,0), 16'd0, 1'b0, 1'b0, 1'b0);
      nav_bus.btn_down = 1'b0;
      nav_bus.btn_left = 1'b1;
      step();
      chk_out("postreset.left", rc(0,0), 16'd0, 1'b0, 1'b0, 1'b0);
      nav_bus.btn_left = 1'b0;
      step();

      // Saturation: alternate right/left to get one move per cycle
      do_load(maze_border, rc(5,5), rc(15,15));
      for (int i = 0; i < 65535; i++) begin
         nav_bus.btn_right = (i % 2 == 0);
         nav_bus.btn_left  = (i % 2 != 0);
         step();
      end
      chk_out("sat.reach", rc(5,6), 16'hFFFF, 1'b1, 1'b0, 1'b0);
      nav_bus.btn_right = 1'b0;
      nav_bus.btn_left  = 1'b1;
      step();
      chk_out("sat.left", rc(5,5), 16'hFFFF, 1'b1, 1'b0, 1'b0);
      nav_bus.btn_right = 1'b1;
      nav_bus.btn_left  = 1'b0;
      step();
      chk_out("sat.right", rc(5,6), 16'hFFFF, 1'b1, 1'b0, 1'b0);
      nav_bus.btn_right = 1'b0;
      step();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
